imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side counterpart of the read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port one word at a time.
- Holds the core in reset (cpu_hold) until the program image is fully loaded, so the fetch path only ever reads a complete image.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load; sampled only in IDLE or DONE.
- num_words  input  ADDR_W+1  number of words to load; sampled on the cycle start is accepted.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word address of the write (the fetch path indexes with pc[31:2]).
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in RECV and WRITE.
- done  output  1  high in DONE.
- cpu_hold  output  1  keeps the core in reset; low only in DONE.
- err  output  1  checksum failure (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0), takes effect immediately, including mid-load:
  - state=IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - Internal byte index=0, word count register=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_hold=1, byte_ready=0.
  - start=1: latch n = min(num_words, DEPTH), mem_addr=0, byte index=0.
  - If n=0, go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1. A byte is accepted when byte_valid & byte_ready.
  - Byte index k (0..3) is written into mem_wdata[8k+7:8k], little-endian.
  - Acceptance of byte index 3 moves to WRITE on the next edge; byte index wraps to 0.
  - byte_valid low: hold state; no timeout.
- WRITE:
  - Exactly one cycle. mem_we=1 with the current mem_addr and mem_wdata; byte_ready=0.
  - If mem_addr == n-1, go to DONE (mem_addr holds its value).
  - Otherwise mem_addr increments and the state returns to RECV.
- DONE:
  - done=1, cpu_hold=0 (unless err=1), byte_ready=0.
  - start=1 restarts exactly as from IDLE and clears err.
- start while busy is ignored. Bytes presented outside RECV are not consumed (byte_ready=0).
- Throughput: 5 cycles per word with byte_valid held high (4 accept cycles plus 1 write cycle).
- mem_we never asserts outside WRITE. mem_addr never exceeds DEPTH-1; there is no wrap-around.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a 32-bit modulo-2^32 sum of every word written.
  - After the last WRITE it enters state CHK and receives 4 more bytes, little-endian, with the same handshake.
  - The checksum bytes are not written to memory.
  - Match: go to DONE with err=0.
  - Mismatch: go to DONE with err=1 and cpu_hold held at 1.
  - n=0 still passes through CHK, with an expected sum of 0.
- Not defined: no CHK state and no sum register; err is tied to 0.

Test Plan:
- Basic load:
  - Stimulus: reset, then start with num_words=2 and bytes 13 00 00 00 93 00 10 00 streamed back-to-back.
  - Required response: writes 0x00000013 at address 0 and 0x00100093 at address 1, 5 cycles apart; done=1, cpu_hold=0.
- Backpressure gaps:
  - Stimulus: as the basic load, with byte_valid low for 3 cycles between each byte.
  - Required response: identical writes, no duplicated bytes, byte_ready stays high throughout RECV.
- Zero and clamp:
  - Stimulus: num_words=0.
  - Required response: DONE one cycle after start, mem_we never asserted.
  - Stimulus: num_words=1500.
  - Required response: exactly 1024 writes, last mem_addr=1023.
- Reset mid-load:
  - Stimulus: rst_n low after 6 bytes accepted.
  - Required response: outputs immediately at reset values (cpu_hold=1, busy=0); a subsequent load starts at address 0 with byte index 0.
- Ignored start and restart:
  - Stimulus: start pulse during RECV.
  - Required response: ignored, no change in mem_addr.
  - Stimulus: start pulse in DONE with num_words=1.
  - Required response: reload writes address 0 again.
- Checksum (with IMEM_LOADER_CHECKSUM_EN):
  - Stimulus: the basic load followed by checksum bytes A6 00 10 00 (0x001000A6).
  - Required response: err=0, cpu_hold=0.
  - Stimulus: checksum bytes A7 00 10 00.
  - Required response: err=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between a byte-stream source, the loader
// and the instruction memory write port.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              err;

  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, err
  );

  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, err
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader; holds the core in reset until the image is in.
// Optional trailing checksum check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W:0]   n_start;
  logic              accept;
  logic              last_word;
  logic              byte_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic [31:0]       chk_q, chk_d;
  logic              err_q, err_d;
`endif

  assign n_start   = (bus.num_words > DEPTH_W) ? DEPTH_W : bus.num_words;
  assign last_word = ({1'b0, addr_q} == (n_q - 1'b1));
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHK);
`else
  assign byte_ready = (state_q == S_RECV);
`endif
  assign accept = bus.byte_valid & byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          n_d    = n_start;
          addr_d = '0;
          idx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
          // An empty image still has to be confirmed by a zero checksum.
          state_d = (n_start == '0) ? S_CHK : S_RECV;
`else
          state_d = (n_start == '0) ? S_DONE : S_RECV;
`endif
        end
      end
      S_RECV: begin
        if (accept) begin
          wdata_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_q;
`endif
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          chk_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            err_d   = ({bus.byte_data, chk_q[23:0]} != sum_q);
            state_d = S_DONE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.done       = (state_q == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHK);
  assign bus.err        = err_q;
  assign bus.cpu_hold   = !((state_q == S_DONE) && !err_q);
`else
  assign bus.busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.err        = 1'b0;
  assign bus.cpu_hold   = (state_q != S_DONE);
`endif

endmodule
